// File: rtl/hs_rr_arbiter.sv
// -----------------------------------------------------------------------------
// hs_rr_arbiter
//
// Round-robin arbiter that shares one valid/ready downstream port between N
// upstream requesters. The winning beat is captured into a single registered
// output stage. When the downstream port is always ready, one beat passes per
// cycle.
//
// Build option:
//   HS_ARB_LOCK_EN  When defined, the i_up_last port and the burst-lock FSM are
//                   present. A granted requester keeps the grant up to and
//                   including its beat with last=1, so bursts do not interleave.
//                   When undefined, arbitration is re-run on every beat.
//
// Parameters:
//   N   number of upstream requesters (2..16)
//   DW  data width per beat
//   IW  grant-index width, derived from N (not meant to be overridden)
//
// Ports:
//   clk         single clock; all state updates on posedge
//   rst         asynchronous, active-high reset
//   i_up_valid  per-requester valid
//   i_up_data   requester k data in bits [k*DW +: DW]
//   o_up_ready  per-requester ready (combinational, at most one bit set)
//   i_up_last   per-requester burst-end marker (HS_ARB_LOCK_EN only)
//   o_dn_valid  registered output valid
//   o_dn_data   registered output data
//   i_dn_ready  downstream ready
//   o_dn_src    index of the requester that produced o_dn_data
// -----------------------------------------------------------------------------
module hs_rr_arbiter #(
  parameter int N  = 4,
  parameter int DW = 32,
  localparam int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    i_up_valid,
  input  logic [N*DW-1:0] i_up_data,
  output logic [N-1:0]    o_up_ready,
`ifdef HS_ARB_LOCK_EN
  input  logic [N-1:0]    i_up_last,
`endif
  output logic            o_dn_valid,
  output logic [DW-1:0]   o_dn_data,
  input  logic            i_dn_ready,
  output logic [IW-1:0]   o_dn_src
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic          en_reg;        // 0 from reset until the first clk edge after release
  logic [IW-1:0] ptr_reg;       // index of the last accepted requester
  logic          dn_valid_reg;
  logic [DW-1:0] dn_data_reg;
  logic [IW-1:0] dn_src_reg;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  logic [DW-1:0] up_data_arr [N];
  logic [N-1:0]  lock_mask;     // requesters currently allowed to compete
  logic [N-1:0]  elig;          // valid and allowed
  logic          free;          // output stage can take a new beat this cycle
  logic          found_hi;
  logic          found_lo;
  logic [IW-1:0] hi_idx;
  logic [IW-1:0] lo_idx;
  logic          grant_found;
  logic [IW-1:0] grant_idx;
  logic          issue;         // a ready is driven this cycle, i.e. a beat is accepted

  // Unpack the flat data bus so the winner can be selected by index.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign up_data_arr[gi] = i_up_data[gi*DW +: DW];
    end
  endgenerate

  assign free = !dn_valid_reg || i_dn_ready;
  assign elig = i_up_valid & lock_mask;

  // ---------------------------------------------------------------------------
  // Round-robin search.
  // Candidates above the pointer take priority over those at or below it; the
  // lowest index within each group wins. This is equivalent to scanning
  // ptr+1, ptr+2, ... modulo N, and needs no modulo arithmetic for N that is
  // not a power of two. The loop runs downward so the final assignment in each
  // group is the lowest eligible index.
  // ---------------------------------------------------------------------------
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (elig[k]) begin
        if (k > int'(ptr_reg)) begin
          hi_idx   = IW'(k);
          found_hi = 1'b1;
        end
        lo_idx   = IW'(k);
        found_lo = 1'b1;
      end
    end
  end

  assign grant_found = found_hi || found_lo;
  assign grant_idx   = found_hi ? hi_idx : lo_idx;

  // en_reg is cleared asynchronously by rst, so ready is also held low while
  // reset is asserted and until the first edge after it is released.
  assign issue = en_reg && free && grant_found;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ready
      assign o_up_ready[gi] = issue && (grant_idx == IW'(gi));
    end
  endgenerate

`ifdef HS_ARB_LOCK_EN
  // ---------------------------------------------------------------------------
  // Burst-lock FSM: FREE / LOCKED(lock_idx_reg)
  // ---------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_FREE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_t;

  lock_state_t   state_reg;
  lock_state_t   state_next;
  logic [IW-1:0] lock_idx_reg;
  logic [IW-1:0] lock_idx_next;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_FREE;
      lock_idx_reg <= '0;
    end else begin
      state_reg    <= state_next;
      lock_idx_reg <= lock_idx_next;
    end
  end

  // Next-state logic. While locked, only the owner can be the winner, so an
  // accept always comes from lock_idx_reg in that state.
  always_comb begin
    state_next    = state_reg;
    lock_idx_next = lock_idx_reg;
    if (issue) begin
      case (state_reg)
        ST_FREE: begin
          if (!i_up_last[grant_idx]) begin
            state_next    = ST_LOCKED;
            lock_idx_next = grant_idx;
          end
        end
        ST_LOCKED: begin
          if (i_up_last[grant_idx]) begin
            state_next = ST_FREE;
          end
        end
        default: state_next = ST_FREE;
      endcase
    end
  end

  // Output logic: the eligibility mask. If the owner drops valid while locked,
  // the mask leaves nobody eligible, so no grant is issued until it returns.
  always_comb begin
    lock_mask = '1;
    if (state_reg == ST_LOCKED) begin
      lock_mask = '0;
      lock_mask[lock_idx_reg] = 1'b1;
    end
  end
`else
  // Without locking, every valid requester competes on every beat.
  assign lock_mask = '1;
`endif

  // ---------------------------------------------------------------------------
  // Enable flag: held low during reset; ready may be driven from the first
  // edge after rst is released.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_reg <= 1'b0;
    end else begin
      en_reg <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage and round-robin pointer.
  // An accept reloads the stage even when it drains in the same cycle, so valid
  // stays high with no bubble. A drain with no accept clears valid, while
  // data and src keep their last values.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg      <= IW'(N - 1);
      dn_valid_reg <= 1'b0;
      dn_data_reg  <= '0;
      dn_src_reg   <= '0;
    end else if (issue) begin
      ptr_reg      <= grant_idx;
      dn_valid_reg <= 1'b1;
      dn_data_reg  <= up_data_arr[grant_idx];
      dn_src_reg   <= grant_idx;
    end else if (dn_valid_reg && i_dn_ready) begin
      dn_valid_reg <= 1'b0;
    end
  end

  assign o_dn_valid = dn_valid_reg;
  assign o_dn_data  = dn_data_reg;
  assign o_dn_src   = dn_src_reg;

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_hs_rr_arbiter
//
// Directed testbench for hs_rr_arbiter with N=4, DW=32. Inputs are driven 1ns
// after each rising edge and outputs are sampled 1ns later, away from the edge.
// -----------------------------------------------------------------------------
module tb_hs_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    up_valid;
  logic [N*DW-1:0] up_data;
  logic [N-1:0]    up_ready;
`ifdef HS_ARB_LOCK_EN
  logic [N-1:0]    up_last;
`endif
  logic            dn_valid;
  logic [DW-1:0]   dn_data;
  logic            dn_ready;
  logic [IW-1:0]   dn_src;

  int n_cmp = 0;
  int n_err = 0;

  hs_rr_arbiter #(.N(N), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_up_valid (up_valid),
    .i_up_data  (up_data),
    .o_up_ready (up_ready),
`ifdef HS_ARB_LOCK_EN
    .i_up_last  (up_last),
`endif
    .o_dn_valid (dn_valid),
    .o_dn_data  (dn_data),
    .i_dn_ready (dn_ready),
    .o_dn_src   (dn_src)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int k, input logic [31:0] d);
    up_data[k*DW +: DW] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b1;
    int exp_src[$];
    logic [31:0] exp_d;

    // ---------------- T1: reset with all requesters valid ----------------
    rst      = 1'b1;
    dn_ready = 1'b1;
    up_valid = 4'hF;
    up_data  = '0;
`ifdef HS_ARB_LOCK_EN
    up_last  = 4'hF;
`endif
    for (int k = 0; k < N; k++) set_data(k, 32'hA000_0000 + k);
    #2;
    chk("t1_ready",    32'(up_ready), 32'h0);
    chk("t1_dn_valid", 32'(dn_valid), 32'h0);
    chk("t1_dn_data",  dn_data,       32'h0);
    chk("t1_dn_src",   32'(dn_src),   32'h0);
    tick();
    chk("t1_ready_hold", 32'(up_ready), 32'h0);
    rst = 1'b0;
    #1;
    // Released, but no edge yet: ready must stay low.
    chk("t1_ready_prerelease", 32'(up_ready), 32'h0);
    tick();
    // Pointer starts at N-1, so requester 0 wins first.
    chk("t1_first_grant", 32'(up_ready), 32'h1);
    chk("t1_dn_valid_post", 32'(dn_valid), 32'h0);

    // ---------------- T2: fairness, one beat per cycle ----------------
    for (int k = 0; k < 5; k++) begin
      tick();
      $display("t2 beat %0d: src=%0d data=%h", k, dn_src, dn_data);
      chk($sformatf("t2_valid_%0d", k), 32'(dn_valid), 32'h1);
      chk($sformatf("t2_src_%0d", k),   32'(dn_src),   32'(k % 4));
      chk($sformatf("t2_data_%0d", k),  dn_data,       32'hA000_0000 + 32'(k % 4));
      chk($sformatf("t2_ready_%0d", k), 32'(up_ready), 32'(1 << ((k + 1) % 4)));
    end
    up_valid = 4'h0;
    tick();
    chk("t2_drain_valid", 32'(dn_valid), 32'h0);
    chk("t2_drain_data",  dn_data,       32'hA000_0000);
    chk("t2_drain_ready", 32'(up_ready), 32'h0);

    // ---------------- T3: backpressure ----------------
    dn_ready = 1'b0;
    up_valid = 4'b0010;
    set_data(1, 32'h1234_5678);
    set_data(3, 32'hDEAD_0003);
`ifdef HS_ARB_LOCK_EN
    up_last  = 4'hF;
`endif
    #1;
    chk("t3_ready_req1", 32'(up_ready), 32'h2);
    tick();
    $display("t3 beat: src=%0d data=%h", dn_src, dn_data);
    up_valid = 4'b1000;   // another requester waits during the stall
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("t3_stall_valid_%0d", c), 32'(dn_valid), 32'h1);
      chk($sformatf("t3_stall_data_%0d", c),  dn_data,       32'h1234_5678);
      chk($sformatf("t3_stall_src_%0d", c),   32'(dn_src),   32'h1);
      chk($sformatf("t3_stall_ready_%0d", c), 32'(up_ready), 32'h0);
    end
    up_valid = 4'b0000;   // the waiting requester withdraws before the stall ends
    dn_ready = 1'b1;
    #1;
    chk("t3_release_valid", 32'(dn_valid), 32'h1);
    chk("t3_release_ready", 32'(up_ready), 32'h0);
    tick();
    chk("t3_after_hs_valid", 32'(dn_valid), 32'h0);
    chk("t3_after_hs_data",  dn_data,       32'h1234_5678);
    tick();
    chk("t3_no_dup_valid", 32'(dn_valid), 32'h0);

    // ---------------- T4: sparse requests, pointer wrap ----------------
    up_valid = 4'b0100;
    set_data(2, 32'hA000_0002);
    set_data(0, 32'hA000_0000);
    #1;
    chk("t4_ready_req2", 32'(up_ready), 32'h4);
    tick();
    $display("t4 beat: src=%0d data=%h", dn_src, dn_data);
    chk("t4_src_2",  32'(dn_src), 32'h2);
    chk("t4_data_2", dn_data,     32'hA000_0002);
    up_valid = 4'b0001;
    #1;
    chk("t4_ready_req0", 32'(up_ready), 32'h1);
    tick();
    $display("t4 beat: src=%0d data=%h", dn_src, dn_data);
    chk("t4_src_0",   32'(dn_src),   32'h0);
    chk("t4_data_0",  dn_data,       32'hA000_0000);
    chk("t4_valid_0", 32'(dn_valid), 32'h1);
    up_valid = 4'b0000;
    tick();
    chk("t4_idle_valid", 32'(dn_valid), 32'h0);

    // ---------------- T5: burst from req1 vs. continuous req3 ----------------
`ifdef HS_ARB_LOCK_EN
    exp_src = '{1, 1, 1, 3};
    up_last = 4'b1000;        // req1 beat 1 is not last; req3 beats are single
`else
    exp_src = '{1, 3, 1, 3, 1};
`endif
    b1 = 0;
    up_valid = 4'b1010;
    set_data(1, 32'hB100_0001);
    set_data(3, 32'hD300_0003);
    foreach (exp_src[i]) begin
      tick();
      exp_d = (exp_src[i] == 1) ? 32'hB100_0001 + 32'(b1) : 32'hD300_0003;
      $display("t5 beat %0d: src=%0d data=%h", i, dn_src, dn_data);
      chk($sformatf("t5_src_%0d", i),  32'(dn_src), 32'(exp_src[i]));
      chk($sformatf("t5_data_%0d", i), dn_data,     exp_d);
`ifdef HS_ARB_LOCK_EN
      // While req1 owns the grant, req3 must not see ready.
      if (i < 2) chk($sformatf("t5_locked_ready_%0d", i), 32'(up_ready), 32'h2);
`endif
      if (exp_src[i] == 1) begin
        b1++;
        set_data(1, 32'hB100_0001 + 32'(b1));
`ifdef HS_ARB_LOCK_EN
        up_last[1] = (b1 == 2);
`endif
        if (b1 == 3) up_valid[1] = 1'b0;
      end
    end
    up_valid = 4'b0000;
    tick();
    chk("t5_idle_valid", 32'(dn_valid), 32'h0);

    // ---------------- T6: reset during a stall ----------------
    dn_ready = 1'b0;
    up_valid = 4'b0100;
    set_data(2, 32'hC0FF_EE02);
`ifdef HS_ARB_LOCK_EN
    up_last  = 4'hF;
`endif
    tick();
    chk("t6_loaded_src", 32'(dn_src), 32'h2);
    tick();
    chk("t6_stall_valid", 32'(dn_valid), 32'h1);
    up_valid = 4'hF;
    set_data(0, 32'h0000_5A5A);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(dn_valid), 32'h0);
    chk("t6_rst_data",  dn_data,       32'h0);
    chk("t6_rst_src",   32'(dn_src),   32'h0);
    chk("t6_rst_ready", 32'(up_ready), 32'h0);
    tick();
    rst = 1'b0;
    dn_ready = 1'b1;
    #1;
    chk("t6_prerelease_ready", 32'(up_ready), 32'h0);
    tick();
    chk("t6_first_grant", 32'(up_ready), 32'h1);
    tick();
    $display("t6 beat: src=%0d data=%h", dn_src, dn_data);
    chk("t6_src_0",  32'(dn_src), 32'h0);
    chk("t6_data_0", dn_data,     32'h0000_5A5A);
    up_valid = 4'h0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
